rs232_rx_fifo: RTL and testbench

- Receive-side byte buffer placed directly downstream of the RS232 receiver; clocked on the same baud clock.
- Captures each received byte when the receiver's ctrl strobe rises and stores it in a circular FIFO.
- Presents the bytes to the consumer through a rd_en/rd_valid read port, with full/empty/count status and a sticky overflow flag.

---
 rtl/rs232_rx_fifo_if.sv | 57 +++++
 rtl/rs232_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_rs232_rx_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rs232_rx_fifo_if.sv
// Bundle of signals between the RS232 receive buffer and its neighbours.
//
// Handshake semantics, in one place:
//   - Write side: the receiver raises rx_ctrl with rx_data valid in the same
//     cycle. Only the 0->1 transition of rx_ctrl is a write request. Holding
//     rx_ctrl high adds nothing more. There is no back-pressure. A byte that
//     arrives while the buffer is full (and no read is taken in that cycle)
//     is dropped and the sticky overflow flag is raised.
//   - Read side: rd_en is a request that is accepted only when empty is low.
//     An accepted request is answered exactly one clock later by a one-cycle
//     rd_valid pulse, with the byte on rd_data. rd_data holds its value
//     between pulses.
//   - overflow stays set until ovf_clr. A new drop in the same cycle as
//     ovf_clr keeps overflow set.
interface rs232_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              rx_ctrl;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;

  // Producer/consumer side: drives the receiver strobe and the read request.
  modport master (
    output rx_ctrl,
    output rx_data,
    output rd_en,
    output ovf_clr,
    input  rd_data,
    input  rd_valid,
    input  empty,
    input  full,
    input  count,
    input  overflow
  );

  // Buffer side.
  modport slave (
    input  rx_ctrl,
    input  rx_data,
    input  rd_en,
    input  ovf_clr,
    output rd_data,
    output rd_valid,
    output empty,
    output full,
    output count,
    output overflow
  );
endinterface

// File: rtl/rs232_rx_fifo.sv
// Receive-side byte buffer behind the RS232 receiver, on the same baud clock.
// Each rising edge of the receiver's rx_ctrl strobe captures one byte into a
// circular buffer of 2**ADDR_W entries. A registered read port returns the
// bytes in arrival order with one clock of latency. Occupancy is tracked by an
// explicit counter, so full and empty never depend on pointer equality.
// Every output comes from a flop or from a decode of flops. No input reaches
// an output combinationally.
module rs232_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  rs232_rx_fifo_if.slave   bus
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ZERO = '0;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  // Storage. It has no reset, because count alone decides which entries are live.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              overflow_r;
  logic              ctrl_q;

  logic              empty_w;
  logic              full_w;
  logic              wr_req;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;

  // Status flags decoded from the registered occupancy only.
  assign empty_w = (count_r == CNT_ZERO);
  assign full_w  = (count_r == CNT_FULL);

  // A write request is the 0->1 transition of the receiver strobe.
  assign wr_req  = bus.rx_ctrl & ~ctrl_q;

  // A read is accepted only when a byte is held at the start of the cycle.
  // For this reason, a write into an empty buffer never falls through in the same cycle.
  assign rd_acc  = bus.rd_en & ~empty_w;

  // A full buffer still takes a byte when a read frees a slot in the same cycle.
  assign wr_acc  = wr_req & (~full_w | rd_acc);

  // The byte is dropped only when the buffer is full and nothing is being read.
  assign ovf_evt = wr_req & full_w & ~rd_acc;

  // Edge-detect register. Reset preloads 1, so a strobe that is already high
  // when reset releases is not taken as a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= 1'b1;
    end else begin
      ctrl_q <= bus.rx_ctrl;
    end
  end

  // Store the incoming byte at the write pointer when the write is accepted.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // Write pointer, which wraps naturally at the buffer depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer, which wraps naturally at the buffer depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Registered read data. It holds its last value when no read is accepted.
  // On a full buffer with a simultaneous read and write, both pointers are
  // equal. The read still sees the old entry, because the store lands at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_acc) begin
      rd_data_r <= mem[rd_ptr];
    end
  end

  // One-cycle valid pulse that follows each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc;
    end
  end

  // Occupancy counter: up on write-only, down on read-only, else steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (ovf_evt) begin
      overflow_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Bench for rs232_rx_fifo. A queue-based reference model predicts the
// occupancy, the flags and the byte order. Every accepted read pushes its
// expected byte onto exp_q. A monitor on the falling edge pops exp_q whenever
// the DUT answers, and checks the status outputs against the model.
module tb_rs232_rx_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs232_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rs232_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] mq[$];      // bytes held by the buffer
  logic [DATA_W-1:0] exp_q[$];   // bytes due on rd_data, in order
  logic [DATA_W-1:0] exp_last;   // value rd_data must hold between pulses
  logic              m_prev;     // last strobe level seen by the model
  logic              m_ovf;
  logic              chk_en = 1'b0;
  int                total = 0;
  int                bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model by one clock, using the inputs applied for that clock.
  task automatic model_step(input logic c, input logic [DATA_W-1:0] d,
                            input logic r, input logic oc);
    int sz;
    logic wr, rd, drop;
    sz   = mq.size();
    wr   = c && !m_prev;
    rd   = r && (sz > 0);
    drop = 1'b0;
    if (rd) exp_q.push_back(mq.pop_front());
    if (wr) begin
      if (sz < DEPTH || rd) mq.push_back(d);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    m_prev = c;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic c, input logic [DATA_W-1:0] d,
                       input logic r, input logic oc);
    bus.rx_ctrl = c;
    bus.rx_data = d;
    bus.rd_en   = r;
    bus.ovf_clr = oc;
    @(posedge clk);
    model_step(c, d, r, oc);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Hold reset for two edges, with the strobe at level c, then release.
  task automatic do_reset(input logic c);
    chk_en      = 1'b0;
    rst         = 1'b1;
    bus.rx_ctrl = c;
    bus.rx_data = '0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    exp_q.delete();
    exp_last = '0;
    m_prev   = 1'b1;
    m_ovf    = 1'b0;
    rst      = 1'b0;
    chk_en   = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() > 0));
      if (bus.rd_valid && exp_q.size() > 0) begin
        exp_last = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(exp_last));
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("rd_data_hold", 32'(bus.rd_data), 32'(exp_last));
      end
      check("count", 32'(bus.count), 32'(mq.size()));
      check("empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic c;
    logic r;

    do_reset(1'b0);
    idle(2);

    // Three pulsed bytes, then three back-to-back reads.
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    drain(3);
    idle(1);

    // A strobe held high for five cycles gives a single write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain(1);

    // A strobe already high at reset release is not captured.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h99, 1'b0, 1'b0);
    idle(2);

    // Fill, overflow, drain, clear.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    push_byte(8'hFF);
    drain(DEPTH);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Full buffer: a write and a read in the same cycle both proceed.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i));
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain(DEPTH);

    // Empty buffer: a write and a read together mean no fall-through.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Forty write/read pairs, wrapping both pointers.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    idle(2);

    // Randomized traffic: a write-heavy phase, then a read-heavy phase.
    c = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) c = ~c;
      r = ($urandom_range(0, 99) < ((i < 300) ? 20 : 75));
      cycle(c, 8'($urandom), r, ($urandom_range(0, 24) == 0));
    end
    idle(1);
    drain(DEPTH + 1);

    // Five bytes buffered, then reset asserted away from any edge.
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_empty", 32'(bus.empty), 32'd1);
    check("async_rst_valid", 32'(bus.rd_valid), 32'd0);
    do_reset(1'b0);
    idle(2);
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
